// File: rtl/alu_src_mux_if.sv
// Operand-B select bus: datapath inputs, the selected operand and debug flags.
// The master drives the sources and select; the slave returns operand and flags.
interface alu_src_mux_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] reg_data;
   logic [WIDTH-1:0] immediate;
   logic [1:0]       alu_src_b;
   logic             clear_flags;
   logic [WIDTH-1:0] alu_input_b;
   logic [WIDTH-1:0] alu_input_b_q;
   logic             illegal_sel;
   logic             illegal_sticky;
   logic [CNT_W-1:0] illegal_count;

   modport master (
      output reg_data, immediate, alu_src_b, clear_flags,
      input  alu_input_b, alu_input_b_q, illegal_sel, illegal_sticky, illegal_count
   );

   modport slave (
      input  reg_data, immediate, alu_src_b, clear_flags,
      output alu_input_b, alu_input_b_q, illegal_sel, illegal_sticky, illegal_count
   );
endinterface

// File: rtl/alu_src_mux.sv
// ALU operand-B source mux (rs2 / immediate / constant) with a registered copy
// and sticky + saturating counters that flag the reserved select code 2'b11.
module alu_src_mux #(
   parameter int WIDTH     = 32,
   parameter int CONST_VAL = 4,
   parameter int CNT_W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   alu_src_mux_if.slave bus
);
   localparam logic [WIDTH-1:0] CONST_B = WIDTH'(CONST_VAL);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] alu_input_b;
   logic             illegal_sel;
   logic [WIDTH-1:0] alu_input_b_d, alu_input_b_q;
   logic             illegal_sticky_d, illegal_sticky_q;
   logic [CNT_W-1:0] illegal_count_d, illegal_count_q;

   // 2'b11 and any unknown select fall through to rs2 so the operand is never X.
   always_comb begin
      alu_input_b = bus.reg_data;
      case (bus.alu_src_b)
         2'b01:   alu_input_b = bus.immediate;
         2'b10:   alu_input_b = CONST_B;
         default: alu_input_b = bus.reg_data;
      endcase
   end

   assign illegal_sel = (bus.alu_src_b == 2'b11);

   always_comb begin
      alu_input_b_d    = alu_input_b;
      illegal_sticky_d = illegal_sticky_q;
      illegal_count_d  = illegal_count_q;
      if (bus.clear_flags) begin
         illegal_sticky_d = 1'b0;
         illegal_count_d  = '0;
      end else if (illegal_sel) begin
         illegal_sticky_d = 1'b1;
         if (illegal_count_q != CNT_MAX)
            illegal_count_d = illegal_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_input_b_q    <= '0;
         illegal_sticky_q <= 1'b0;
         illegal_count_q  <= '0;
      end else begin
         alu_input_b_q    <= alu_input_b_d;
         illegal_sticky_q <= illegal_sticky_d;
         illegal_count_q  <= illegal_count_d;
      end
   end

   assign bus.alu_input_b    = alu_input_b;
   assign bus.illegal_sel    = illegal_sel;
   assign bus.alu_input_b_q  = alu_input_b_q;
   assign bus.illegal_sticky = illegal_sticky_q;
   assign bus.illegal_count  = illegal_count_q;
endmodule

// File: tb/tb_alu_src_mux.sv
// Directed and randomized checks of alu_src_mux against a table-driven reference
// model of the operand select, sticky flag and saturating counter.
module tb_alu_src_mux;
   localparam int WIDTH = 32;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   // reference state
   logic [WIDTH-1:0] m_q;
   bit               m_sticky;
   int               m_cnt;

   alu_src_mux_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   alu_src_mux #(.WIDTH(WIDTH), .CONST_VAL(4), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_mux(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] i);
      logic [WIDTH-1:0] src [4];
      src[0] = r;
      src[1] = i;
      src[2] = 32'd4;
      src[3] = r;
      return src[sel];
   endfunction

   task automatic check_comb();
      chk("alu_input_b", bus.alu_input_b,
          ref_mux(bus.alu_src_b, bus.reg_data, bus.immediate));
      chk("illegal_sel", bus.illegal_sel, (bus.alu_src_b == 2'b11));
   endtask

   task automatic check_regs(input string tag);
      chk({tag, "_q"},      bus.alu_input_b_q, m_q);
      chk({tag, "_sticky"}, bus.illegal_sticky, m_sticky);
      chk({tag, "_count"},  bus.illegal_count, m_cnt);
   endtask

   // drive at negedge, check comb, clock once, check registered outputs
   task automatic step(input logic [1:0] sel, input logic [WIDTH-1:0] r,
                       input logic [WIDTH-1:0] i, input bit clr, input string tag);
      @(negedge clk);
      bus.alu_src_b   = sel;
      bus.reg_data    = r;
      bus.immediate   = i;
      bus.clear_flags = clr;
      #1 check_comb();
      @(posedge clk);
      m_q = ref_mux(sel, r, i);
      if (clr) begin
         m_sticky = 0;
         m_cnt    = 0;
      end else if (sel == 2'b11) begin
         m_sticky = 1;
         m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
      #1 check_regs(tag);
   endtask

   task automatic model_reset();
      m_q      = '0;
      m_sticky = 0;
      m_cnt    = 0;
   endtask

   initial begin
      model_reset();
      bus.reg_data    = 32'hAAAA_AAAA;
      bus.immediate   = 32'hDDDD_DDDD;
      bus.alu_src_b   = 2'b00;
      bus.clear_flags = 1'b0;

      // reset state and clock-free combinational path
      #10;
      check_regs("reset");
      chk("tp_sel00", bus.alu_input_b, 32'hAAAA_AAAA);
      chk("tp_ill00", bus.illegal_sel, 1'b0);
      bus.alu_src_b = 2'b01; #1;
      chk("tp_sel01", bus.alu_input_b, 32'hDDDD_DDDD);
      bus.alu_src_b = 2'b10; #1;
      chk("tp_sel10", bus.alu_input_b, 32'h0000_0004);
      bus.alu_src_b = 2'b11; #1;
      chk("tp_sel11", bus.alu_input_b, 32'hAAAA_AAAA);
      chk("tp_ill11", bus.illegal_sel, 1'b1);
      bus.alu_src_b = 2'b00;

      @(negedge clk);
      rst = 1'b0;

      step(2'b11, 32'hAAAA_AAAA, 32'hDDDD_DDDD, 1'b0, "first_ill");
      chk("first_ill_cnt1", bus.illegal_count, 8'd1);

      // saturation
      for (int k = 0; k < 300; k++)
         step(2'b11, $urandom, $urandom, 1'b0, "sat");
      chk("sat_255", bus.illegal_count, 8'd255);
      chk("sat_sticky", bus.illegal_sticky, 1'b1);

      // clear wins over a simultaneous illegal select
      step(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "clr_pri");
      chk("clr_pri_cnt0", bus.illegal_count, 8'd0);

      // build count to 5, then async reset between edges
      for (int k = 0; k < 5; k++)
         step(2'b11, 32'hAAAA_AAAA, 32'hDDDD_DDDD, 1'b0, "cnt5");
      chk("cnt5_val", bus.illegal_count, 8'd5);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_count",  bus.illegal_count, 8'd0);
      chk("arst_sticky", bus.illegal_sticky, 1'b0);
      chk("arst_q",      bus.alu_input_b_q, 32'd0);
      bus.alu_src_b = 2'b01; #1;
      chk("arst_comb", bus.alu_input_b, 32'hDDDD_DDDD);
      @(posedge clk); #1;
      model_reset();
      check_regs("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      step(2'b01, 32'hAAAA_AAAA, 32'hDDDD_DDDD, 1'b0, "post_rst");
      chk("post_rst_imm", bus.alu_input_b_q, 32'hDDDD_DDDD);

      // randomized traffic
      for (int k = 0; k < 400; k++)
         step(2'($urandom_range(3)), $urandom, $urandom,
              ($urandom_range(7) == 0), "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
